redmule_w_pingpong_buffer: RTL and testbench

//  Weight (W) staging buffer between the W stream source and the CE array. Accepts W rows
//  (TOT_DEPTH elements each) from the streamer and holds up to ARRAY_HEIGHT rows per bank.
//  On each shift it presents one column: one element per array row. Two banks ping-pong,
//  so the next tile fills while the current one drains. Driven by w_buffer_ctrl_t; reports
//  w_buffer_flgs_t.

---
 rtl/redmule_pkg.sv | 26 ++
 rtl/redmule_w_bank.sv | 108 ++++++++++
 rtl/redmule_w_pingpong_buffer.sv | 87 ++++++++
 tb/tb_redmule_w_pingpong_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types and default geometry for the RedMulE weight staging path.
package redmule_pkg;

  localparam int unsigned RM_ARRAY_HEIGHT = 4;
  localparam int unsigned RM_TOT_DEPTH    = 16;
  localparam int unsigned RM_BITW         = 16;
  localparam int unsigned RM_DATAW        = RM_TOT_DEPTH * RM_BITW;

  localparam int unsigned W_BANKS     = 2;
  localparam int unsigned W_ROW_IDX_W = $clog2(RM_ARRAY_HEIGHT);
  localparam int unsigned W_COL_IDX_W = $clog2(RM_TOT_DEPTH);

  typedef enum logic [1:0] {W_EMPTY, W_FILLING, W_FULL} w_bank_state_e;

  typedef struct packed {
    logic                   load;
    logic                   shift;
    logic [W_COL_IDX_W-1:0] cols_lftovr;
    logic [W_ROW_IDX_W-1:0] rows_lftovr;
  } w_buffer_ctrl_t;

  typedef struct packed {
    logic [RM_ARRAY_HEIGHT-1:0] empty;
  } w_buffer_flgs_t;

endpackage

// File: rtl/redmule_w_bank.sv
// One weight bank: row storage, fill/drain counters, latched tile sizes and bank state.
module redmule_w_bank
  import redmule_pkg::*;
#(
  parameter int unsigned ARRAY_HEIGHT = RM_ARRAY_HEIGHT,
  parameter int unsigned TOT_DEPTH    = RM_TOT_DEPTH,
  parameter int unsigned BITW         = RM_BITW,
  parameter int unsigned DATAW        = RM_DATAW
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              wr_en_i,
  input  logic [$clog2(ARRAY_HEIGHT)-1:0]   rows_lftovr_i,
  input  logic [$clog2(TOT_DEPTH)-1:0]      cols_lftovr_i,
  input  logic [DATAW-1:0]                  w_data_i,
  input  logic                              shift_en_i,
  output w_bank_state_e                     state_o,
  output logic [$clog2(ARRAY_HEIGHT+1)-1:0] eff_rows_o,
  output logic                              fill_done_o,
  output logic                              drain_done_o,
  output logic [ARRAY_HEIGHT*BITW-1:0]      col_o
);

  localparam int unsigned ROW_IW = $clog2(ARRAY_HEIGHT);
  localparam int unsigned COL_IW = $clog2(TOT_DEPTH);
  localparam int unsigned ROW_CW = $clog2(ARRAY_HEIGHT + 1);
  localparam int unsigned COL_CW = $clog2(TOT_DEPTH + 1);

  w_bank_state_e     state_q, state_d;
  logic [ROW_IW-1:0] fill_row_q;
  logic [COL_IW-1:0] col_q;
  logic [ROW_CW-1:0] eff_rows_q, eff_rows;
  logic [COL_CW-1:0] eff_cols_q, eff_cols;
  logic [BITW-1:0]   mem_q [ARRAY_HEIGHT][TOT_DEPTH];

  // Sizes track ctrl only until the first row lands; afterwards the latched copy rules.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    eff_rows = eff_rows_q;
    eff_cols = eff_cols_q;
    if (state_q == W_EMPTY) begin
      eff_rows = (rows_lftovr_i == '0) ? ROW_CW'(ARRAY_HEIGHT) : ROW_CW'(rows_lftovr_i);
      eff_cols = (cols_lftovr_i == '0) ? COL_CW'(TOT_DEPTH) : COL_CW'(cols_lftovr_i);
    end
  end

  assign fill_done_o  = wr_en_i && ((ROW_CW'(fill_row_q) + ROW_CW'(1)) == eff_rows);
  assign drain_done_o = shift_en_i && ((COL_CW'(col_q) + COL_CW'(1)) == eff_cols_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_EMPTY:   if (wr_en_i) state_d = fill_done_o ? W_FULL : W_FILLING;
      W_FILLING: if (fill_done_o) state_d = W_FULL;
      W_FULL:    if (drain_done_o) state_d = W_EMPTY;
      default:   state_d = W_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= W_EMPTY;
      fill_row_q <= '0;
      col_q      <= '0;
      eff_rows_q <= '0;
      eff_cols_q <= '0;
    end else if (clear_i) begin
      state_q    <= W_EMPTY;
      fill_row_q <= '0;
      col_q      <= '0;
      eff_rows_q <= '0;
      eff_cols_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en_i) begin
        eff_rows_q <= eff_rows;
        eff_cols_q <= eff_cols;
        fill_row_q <= fill_done_o ? '0 : fill_row_q + 1'b1;
      end
      if (shift_en_i) col_q <= drain_done_o ? '0 : col_q + 1'b1;
    end
  end

  // NOTE: storage is reset on purpose: unwritten rows and columns must read as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < ARRAY_HEIGHT; r++)
        for (int c = 0; c < TOT_DEPTH; c++) mem_q[r][c] <= '0;
    end else if (clear_i || drain_done_o) begin
      for (int r = 0; r < ARRAY_HEIGHT; r++)
        for (int c = 0; c < TOT_DEPTH; c++) mem_q[r][c] <= '0;
    end else if (wr_en_i) begin
      for (int c = 0; c < TOT_DEPTH; c++)
        mem_q[fill_row_q][c] <= (COL_CW'(c) < eff_cols) ? w_data_i[c*BITW +: BITW] : '0;
    end
  end

  always_comb begin
    col_o = '0;
    for (int r = 0; r < ARRAY_HEIGHT; r++) col_o[r*BITW +: BITW] = mem_q[r][col_q];
  end

  assign state_o    = state_q;
  assign eff_rows_o = eff_rows_q;

endmodule

// File: rtl/redmule_w_pingpong_buffer.sv
// Ping-pong weight buffer: one bank fills from the W stream while the other drains columns.
module redmule_w_pingpong_buffer
  import redmule_pkg::*;
#(
  parameter int unsigned ARRAY_HEIGHT = RM_ARRAY_HEIGHT,
  parameter int unsigned TOT_DEPTH    = RM_TOT_DEPTH,
  parameter int unsigned BITW         = RM_BITW,
  parameter int unsigned DATAW        = RM_DATAW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  w_buffer_ctrl_t               ctrl_i,
  output w_buffer_flgs_t               flags_o,
  input  logic [DATAW-1:0]             w_data_i,
  input  logic                         w_valid_i,
  output logic                         w_ready_o,
  output logic [ARRAY_HEIGHT*BITW-1:0] w_o,
  output logic                         w_valid_o
);

  localparam int unsigned ROW_CW = $clog2(ARRAY_HEIGHT + 1);

  logic                         fill_ptr_q, drain_ptr_q;
  logic                         handshake;
  w_bank_state_e                bank_state [W_BANKS];
  logic [ROW_CW-1:0]            bank_rows  [W_BANKS];
  logic [ARRAY_HEIGHT*BITW-1:0] bank_col   [W_BANKS];
  logic [W_BANKS-1:0]           wr_en, shift_en, fill_done, drain_done;

  // Ready depends only on ctrl and registered state, never on w_valid_i.
  assign w_ready_o = ctrl_i.load && (bank_state[fill_ptr_q] != W_FULL);
  assign handshake = w_valid_i && w_ready_o;
  assign w_valid_o = (bank_state[drain_ptr_q] == W_FULL);
  assign w_o       = bank_col[drain_ptr_q];

  for (genvar b = 0; b < W_BANKS; b++) begin : g_bank
    assign wr_en[b]    = handshake && (fill_ptr_q == 1'(b));
    assign shift_en[b] = ctrl_i.shift && w_valid_o && (drain_ptr_q == 1'(b));

    redmule_w_bank #(
      .ARRAY_HEIGHT (ARRAY_HEIGHT),
      .TOT_DEPTH    (TOT_DEPTH),
      .BITW         (BITW),
      .DATAW        (DATAW)
    ) i_bank (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .wr_en_i       (wr_en[b]),
      .rows_lftovr_i (ctrl_i.rows_lftovr),
      .cols_lftovr_i (ctrl_i.cols_lftovr),
      .w_data_i      (w_data_i),
      .shift_en_i    (shift_en[b]),
      .state_o       (bank_state[b]),
      .eff_rows_o    (bank_rows[b]),
      .fill_done_o   (fill_done[b]),
      .drain_done_o  (drain_done[b]),
      .col_o         (bank_col[b])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
    end else if (clear_i) begin
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
    end else begin
      if (|fill_done)  fill_ptr_q  <= ~fill_ptr_q;
      if (|drain_done) drain_ptr_q <= ~drain_ptr_q;
    end
  end

  always_comb begin
    flags_o = '1;
    for (int r = 0; r < ARRAY_HEIGHT; r++)
      flags_o.empty[r] = !(w_valid_o && (ROW_CW'(r) < bank_rows[drain_ptr_q]));
  end

  // A shift with no valid column is dropped by the datapath; flag it for the upstream controller.
  shift_without_valid : assert property (
    @(posedge clk_i) disable iff (rst_i || clear_i) ctrl_i.shift |-> w_valid_o
  ) else $warning("shift requested while no weight column is valid; ignored");

endmodule

// File: tb/tb_redmule_w_pingpong_buffer.sv
// Bench for the ping-pong weight buffer: directed scenarios plus random traffic against a tile-queue model.
module tb_redmule_w_pingpong_buffer;
  import redmule_pkg::*;

  typedef struct packed {
    int               rows;
    int               cols;
    logic [4095:0]    d;     // element (r,c) at [(r*16+c)*16 +: 16]
  } tile_t;

  logic           clk = 1'b0;
  logic           rst, clear;
  w_buffer_ctrl_t ctrl;
  w_buffer_flgs_t flags;
  logic [255:0]   w_data;
  logic           w_valid, w_ready;
  logic [63:0]    w_o;
  logic           w_valid_o;

  int checks = 0;
  int errors = 0;

  // Model: completed tiles wait in order of arrival; one tile may be half-loaded.
  tile_t full_q[$];
  tile_t part;
  bit    part_active;
  int    part_n;
  int    mcol;

  always #5 clk = ~clk;

  redmule_w_pingpong_buffer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (clear),
    .ctrl_i    (ctrl),
    .flags_o   (flags),
    .w_data_i  (w_data),
    .w_valid_i (w_valid),
    .w_ready_o (w_ready),
    .w_o       (w_o),
    .w_valid_o (w_valid_o)
  );

  function automatic void model_reset();
    full_q.delete();
    part        = '0;
    part_active = 1'b0;
    part_n      = 0;
    mcol        = 0;
  endfunction

  function automatic logic m_ready();
    return ctrl.load && (full_q.size() < 2);
  endfunction

  function automatic logic m_valid();
    return full_q.size() > 0;
  endfunction

  function automatic logic [63:0] m_w_o();
    logic [63:0] v = '0;
    tile_t t;
    if (full_q.size() > 0) begin
      t = full_q[0];
      for (int r = 0; r < 4; r++) v[r*16 +: 16] = t.d[(r*16 + mcol)*16 +: 16];
    end else if (part_active) begin
      for (int r = 0; r < 4; r++) v[r*16 +: 16] = part.d[(r*16)*16 +: 16];
    end
    return v;
  endfunction

  function automatic logic [3:0] m_empty();
    logic [3:0] e = 4'hF;
    tile_t t;
    if (full_q.size() > 0) begin
      t = full_q[0];
      for (int r = 0; r < 4; r++) if (r < t.rows) e[r] = 1'b0;
    end
    return e;
  endfunction

  // Advance the model by one clock using the inputs that were applied for that cycle.
  function automatic void model_step();
    bit hs, sh;
    tile_t t;
    if (clear) begin
      model_reset();
      return;
    end
    hs = w_valid && m_ready();
    sh = ctrl.shift && m_valid();
    if (sh) begin
      t = full_q[0];
      mcol++;
      if (mcol == t.cols) begin
        void'(full_q.pop_front());
        mcol = 0;
      end
    end
    if (hs) begin
      if (!part_active) begin
        part        = '0;
        part.rows   = (ctrl.rows_lftovr == 0) ? 4 : int'(ctrl.rows_lftovr);
        part.cols   = (ctrl.cols_lftovr == 0) ? 16 : int'(ctrl.cols_lftovr);
        part_active = 1'b1;
        part_n      = 0;
      end
      for (int c = 0; c < 16; c++)
        part.d[(part_n*16 + c)*16 +: 16] = (c < part.cols) ? w_data[c*16 +: 16] : 16'h0;
      part_n++;
      if (part_n == part.rows) begin
        full_q.push_back(part);
        part_active = 1'b0;
      end
    end
  endfunction

  task automatic drive(input logic ld, input logic sh, input logic [1:0] rl,
                       input logic [3:0] cl, input logic vl, input logic [255:0] d);
    clear            = 1'b0;
    ctrl.load        = ld;
    ctrl.shift       = sh;
    ctrl.rows_lftovr = rl;
    ctrl.cols_lftovr = cl;
    w_valid          = vl;
    w_data           = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [255:0] row_pat(input int r);
    logic [255:0] v;
    for (int c = 0; c < 16; c++) v[c*16 +: 16] = 16'(r*16 + c);
    return v;
  endfunction

  function automatic logic [255:0] rand_row();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    #4;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", w_ready); end
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", w_valid_o); end
    checks++; if (w_o !== 64'h0) begin errors++; $display("FAIL reset_w_o: got %h want 0", w_o); end
    checks++; if (flags.empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %h want F", flags.empty); end
    tick();
  endtask

  task automatic test_full_tile();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, row_pat(r));
      #4;
      checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL full_ready row %0d: got %b want 1", r, w_ready); end
      checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL full_early_valid row %0d: got %b want 0", r, w_valid_o); end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", w_valid_o); end
    checks++; if (flags.empty !== 4'h0) begin errors++; $display("FAIL full_empty: got %h want 0", flags.empty); end
    tick();
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, '0);
      #4;
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (w_o[r*16 +: 16] !== 16'(r*16 + c)) begin
          errors++; $display("FAIL full_col c%0d r%0d: got %h want %h", c, r, w_o[r*16 +: 16], 16'(r*16 + c));
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL full_drained_valid: got %b want 0", w_valid_o); end
    checks++; if (flags.empty !== 4'hF) begin errors++; $display("FAIL full_drained_empty: got %h want F", flags.empty); end
    tick();
  endtask

  task automatic test_leftover();
    logic [255:0] rows [3];
    do_reset();
    for (int r = 0; r < 3; r++) begin
      rows[r] = rand_row();
      drive(1'b1, 1'b0, 2'd3, 4'd5, 1'b1, rows[r]);
      #4;
      checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL lftovr_early_valid row %0d: got %b want 0", r, w_valid_o); end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL lftovr_valid: got %b want 1", w_valid_o); end
    checks++; if (flags.empty !== 4'b1000) begin errors++; $display("FAIL lftovr_empty: got %b want 1000", flags.empty); end
    checks++; if (w_o[63:48] !== 16'h0) begin errors++; $display("FAIL lftovr_row3: got %h want 0", w_o[63:48]); end
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL lftovr_shift_valid c%0d: got %b want 1", c, w_valid_o); end
      for (int r = 0; r < 3; r++) begin
        checks++;
        if (w_o[r*16 +: 16] !== rows[r][c*16 +: 16]) begin
          errors++; $display("FAIL lftovr_col c%0d r%0d: got %h want %h", c, r, w_o[r*16 +: 16], rows[r][c*16 +: 16]);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL lftovr_freed_valid: got %b want 0", w_valid_o); end
    checks++; if (flags.empty !== 4'hF) begin errors++; $display("FAIL lftovr_freed_empty: got %h want F", flags.empty); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] a [4];
    logic [255:0] b [4];
    do_reset();
    for (int r = 0; r < 4; r++) begin
      a[r] = rand_row();
      b[r] = rand_row();
      drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, a[r]);
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      if (c < 4) drive(1'b1, 1'b1, 2'd0, 4'd0, 1'b1, b[c]);
      else       drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid c%0d: got %b want 1", c, w_valid_o); end
      checks++; if (w_o[15:0] !== a[0][c*16 +: 16]) begin errors++; $display("FAIL b2b_bank0 c%0d: got %h want %h", c, w_o[15:0], a[0][c*16 +: 16]); end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_swap_valid: got %b want 1", w_valid_o); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (w_o[r*16 +: 16] !== b[r][15:0]) begin
        errors++; $display("FAIL b2b_bank1_col0 r%0d: got %h want %h", r, w_o[r*16 +: 16], b[r][15:0]);
      end
    end
    tick();
  endtask

  task automatic test_both_full();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, rand_row());
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 1'b1, 2'd0, 4'd0, 1'b1, rand_row());
      #4;
      checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL both_full_ready c%0d: got %b want 0", c, w_ready); end
      tick();
    end
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL both_full_freed_ready: got %b want 1", w_ready); end
    checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL both_full_bank1_valid: got %b want 1", w_valid_o); end
    tick();
  endtask

  task automatic test_clear_and_reset();
    logic [255:0] d;
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      for (int r = 0; r < 2; r++) begin
        drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, rand_row());
        tick();
      end
      if (mode == 0) begin
        drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
        clear = 1'b1;
        tick();
      end else begin
        do_reset();
      end
      drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL clr%0d_valid: got %b want 0", mode, w_valid_o); end
      checks++; if (flags.empty !== 4'hF) begin errors++; $display("FAIL clr%0d_empty: got %h want F", mode, flags.empty); end
      checks++; if (w_o !== 64'h0) begin errors++; $display("FAIL clr%0d_w_o: got %h want 0", mode, w_o); end
      tick();
      d = rand_row();
      drive(1'b1, 1'b0, 2'd1, 4'd0, 1'b1, d);
      tick();
      drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL clr%0d_refill_valid: got %b want 1", mode, w_valid_o); end
      checks++; if (w_o !== {48'h0, d[15:0]}) begin errors++; $display("FAIL clr%0d_refill_w_o: got %h want %h", mode, w_o, {48'h0, d[15:0]}); end
      checks++; if (flags.empty !== 4'b1110) begin errors++; $display("FAIL clr%0d_refill_empty: got %b want 1110", mode, flags.empty); end
      tick();
    end
  endtask

  task automatic test_shift_empty_and_latch();
    logic [255:0] r0, r1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL idle_shift_valid %0d: got %b want 0", k, w_valid_o); end
      checks++; if (flags.empty !== 4'hF) begin errors++; $display("FAIL idle_shift_empty %0d: got %h want F", k, flags.empty); end
      tick();
    end
    r0 = rand_row();
    r1 = rand_row();
    drive(1'b1, 1'b0, 2'd2, 4'd3, 1'b1, r0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, r1);
    tick();
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL latch_valid: got %b want 1", w_valid_o); end
    checks++; if (flags.empty !== 4'b1100) begin errors++; $display("FAIL latch_empty: got %b want 1100", flags.empty); end
    checks++; if (w_o !== {32'h0, r1[15:0], r0[15:0]}) begin errors++; $display("FAIL latch_col0: got %h want %h", w_o, {32'h0, r1[15:0], r0[15:0]}); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, '0);
      #4;
      checks++; if (w_valid_o !== 1'b1) begin errors++; $display("FAIL latch_shift_valid c%0d: got %b want 1", c, w_valid_o); end
      checks++; if (w_o[31:16] !== r1[c*16 +: 16]) begin errors++; $display("FAIL latch_row1 c%0d: got %h want %h", c, w_o[31:16], r1[c*16 +: 16]); end
      tick();
    end
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, '0);
    #4;
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL latch_freed_valid: got %b want 0", w_valid_o); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(3) != 0), ($urandom_range(2) != 0), 2'($urandom_range(3)),
            (($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15))), 1'($urandom), rand_row());
      clear = ($urandom_range(79) == 0);
      #4;
      checks++; if (w_ready !== m_ready()) begin errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", i, w_ready, m_ready()); end
      checks++; if (w_valid_o !== m_valid()) begin errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", i, w_valid_o, m_valid()); end
      checks++; if (w_o !== m_w_o()) begin errors++; $display("FAIL rand_w_o cyc %0d: got %h want %h", i, w_o, m_w_o()); end
      checks++; if (flags.empty !== m_empty()) begin errors++; $display("FAIL rand_empty cyc %0d: got %b want %b", i, flags.empty, m_empty()); end
      tick();
    end
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    ctrl  = '0;
    w_data  = '0;
    w_valid = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_full_tile();
    test_leftover();
    test_back_to_back();
    test_both_full();
    test_clear_and_reset();
    test_shift_empty_and_latch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
